// File: rtl/phy_rx_aligner.sv
// Serial-to-parallel receive aligner: hunts for COM, byte-aligns, declares sync,
// strips COM idles and packs data bytes into DATA_W-bit words.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// LOOKING    | bit-by-bit hunt for COM in the serial stream
// SYNCING    | byte-aligned, counting consecutive COMs toward SYNC_COUNT
// ACTIVE     | synchronised; data bytes packed, COM idles dropped, gap watched
module phy_rx_aligner #(
  parameter int unsigned DATA_W     = 32,
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4,
  parameter int unsigned MAX_GAP    = 64
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              sincronizar_bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] ST_LOOKING = 2'd0;
  localparam logic [1:0] ST_SYNCING = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  logic [1:0]        state;
  logic [7:0]        shift;
  logic [7:0]        shift_nxt;
  logic [2:0]        bit_cnt;
  logic [3:0]        com_cnt;
  logic [7:0]        gap_cnt;
  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-1:0] word_buf;
  logic [DATA_W-1:0] word_nxt;
  logic              byte_done;
  logic              is_com;

  assign shift_nxt = {shift[6:0], data_in};
  assign is_com    = (shift_nxt == COM);
  assign byte_done = (state != ST_LOOKING) && (bit_cnt == 3'd7);

  // Slot 0 lands in the MSBs so the first received byte leads the word.
  always_comb begin
    word_nxt = word_buf;
    for (int i = 0; i < NB; i++) begin
      if (byte_idx == IDX_W'(i)) begin
        word_nxt[DATA_W-8-8*i +: 8] = shift_nxt;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state           <= ST_LOOKING;
      shift           <= 8'd0;
      bit_cnt         <= 3'd0;
      com_cnt         <= 4'd0;
      gap_cnt         <= 8'd0;
      byte_idx        <= '0;
      word_buf        <= '0;
      data_out        <= '0;
      valid_out       <= 1'b0;
      sincronizar_bus <= 1'b0;
    end else begin
      shift     <= shift_nxt;
      valid_out <= 1'b0;
      if (state != ST_LOOKING) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      case (state)
        ST_LOOKING: begin
          if (is_com) begin
            bit_cnt <= 3'd0;
            com_cnt <= 4'd1;
            if (SYNC_COUNT == 1) begin
              state           <= ST_ACTIVE;
              sincronizar_bus <= 1'b1;
            end else begin
              state <= ST_SYNCING;
            end
          end
        end
        ST_SYNCING: begin
          if (byte_done) begin
            if (is_com) begin
              com_cnt <= com_cnt + 4'd1;
              if (com_cnt == 4'(SYNC_COUNT - 1)) begin
                state           <= ST_ACTIVE;
                sincronizar_bus <= 1'b1;
              end
            end else begin
              // hunt restarts next cycle; this edge does not realign
              state   <= ST_LOOKING;
              com_cnt <= 4'd0;
            end
          end
        end
        ST_ACTIVE: begin
          if (byte_done) begin
            if (is_com) begin
              gap_cnt <= 8'd0;
            end else if (gap_cnt == 8'(MAX_GAP)) begin
              // loss outranks word completion: partial or full word is dropped
              state           <= ST_LOOKING;
              sincronizar_bus <= 1'b0;
              byte_idx        <= '0;
              gap_cnt         <= 8'd0;
              com_cnt         <= 4'd0;
            end else begin
              gap_cnt  <= gap_cnt + 8'd1;
              word_buf <= word_nxt;
              if (byte_idx == IDX_W'(NB - 1)) begin
                data_out  <= word_nxt;
                valid_out <= 1'b1;
                byte_idx  <= '0;
              end else begin
                byte_idx <= byte_idx + 1'b1;
              end
            end
          end
        end
        default: state <= ST_LOOKING;
      endcase
    end
  end

endmodule
